// File: rtl/vcache_dma_arbiter_if.sv
// Bundles the cache-side and memory-side DMA signals of vcache_dma_arbiter.
// Modport master: the arbiter's view. Modport slave: the view of the
// vcaches and memory around it.
//   dma_pkt_*    : per-cache request packets {write_not_read, addr}
//   dma_wdata_*  : per-cache write beats
//   dma_rdata_*  : fill beats (data broadcast, valid one-hot)
//   mem_*        : single memory-side DMA channel
//   stat_*       : per-cache grant / wait counters
interface vcache_dma_arbiter_if #(
  parameter int unsigned num_cache_p  = 4,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
) ();
  localparam int unsigned pkt_w = addr_width_p + 1;

  logic [num_cache_p*pkt_w-1:0]        dma_pkt_i;
  logic [num_cache_p-1:0]              dma_pkt_v_i;
  logic [num_cache_p-1:0]              dma_pkt_yumi_o;
  logic [num_cache_p*data_width_p-1:0] dma_wdata_i;
  logic [num_cache_p-1:0]              dma_wdata_v_i;
  logic [num_cache_p-1:0]              dma_wdata_yumi_o;
  logic [data_width_p-1:0]             dma_rdata_o;
  logic [num_cache_p-1:0]              dma_rdata_v_o;
  logic [num_cache_p-1:0]              dma_rdata_ready_i;
  logic [pkt_w-1:0]                    mem_pkt_o;
  logic                                mem_pkt_v_o;
  logic                                mem_pkt_yumi_i;
  logic [data_width_p-1:0]             mem_wdata_o;
  logic                                mem_wdata_v_o;
  logic                                mem_wdata_yumi_i;
  logic [data_width_p-1:0]             mem_rdata_i;
  logic                                mem_rdata_v_i;
  logic                                mem_rdata_ready_o;
  logic [num_cache_p*32-1:0]           stat_grant_o;
  logic [num_cache_p*32-1:0]           stat_wait_o;

  modport master (
    input  dma_pkt_i, dma_pkt_v_i, dma_wdata_i, dma_wdata_v_i, dma_rdata_ready_i,
           mem_pkt_yumi_i, mem_wdata_yumi_i, mem_rdata_i, mem_rdata_v_i,
    output dma_pkt_yumi_o, dma_wdata_yumi_o, dma_rdata_o, dma_rdata_v_o,
           mem_pkt_o, mem_pkt_v_o, mem_wdata_o, mem_wdata_v_o, mem_rdata_ready_o,
           stat_grant_o, stat_wait_o
  );

  modport slave (
    output dma_pkt_i, dma_pkt_v_i, dma_wdata_i, dma_wdata_v_i, dma_rdata_ready_i,
           mem_pkt_yumi_i, mem_wdata_yumi_i, mem_rdata_i, mem_rdata_v_i,
    input  dma_pkt_yumi_o, dma_wdata_yumi_o, dma_rdata_o, dma_rdata_v_o,
           mem_pkt_o, mem_pkt_v_o, mem_wdata_o, mem_wdata_v_o, mem_rdata_ready_o,
           stat_grant_o, stat_wait_o
  );
endinterface

// File: rtl/vcache_dma_arbiter.sv
// Shares one memory DMA channel among num_cache_p vcaches.
// Request packets are arbitrated round-robin. A write locks the channel to its
// owner for block_size_in_words_p data beats. Read fills are steered back to
// the requester through an in-order ID FIFO.
// Ports: clk_i, reset_n_i (async, active low), bus (vcache_dma_arbiter_if.master).
// Optional: define VCACHE_DMA_ARB_STATS_EN to build the per-cache grant/wait
// counters; otherwise the stat outputs are tied to 0.
module vcache_dma_arbiter #(
  parameter int unsigned num_cache_p           = 4,
  parameter int unsigned addr_width_p          = 32,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 8,
  parameter int unsigned rd_fifo_els_p         = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  vcache_dma_arbiter_if.master bus
);
  localparam int unsigned pkt_w = addr_width_p + 1;
  localparam int unsigned id_w  = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;
  localparam int unsigned cnt_w = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
  localparam int unsigned ptr_w = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int unsigned occ_w = $clog2(rd_fifo_els_p + 1);

  typedef enum logic {ST_IDLE, ST_WDATA} state_e;

  state_e            state_q, state_d;
  logic [id_w-1:0]   rr_q, rr_d;
  logic [id_w-1:0]   owner_q, owner_d;
  logic [id_w-1:0]   grant_q, grant_d;
  logic              offered_q, offered_d;
  logic [cnt_w-1:0]  wcnt_q, wcnt_d;
  logic [cnt_w-1:0]  rcnt_q, rcnt_d;
  logic [id_w-1:0]   fifo_mem_q [rd_fifo_els_p];
  logic [id_w-1:0]   fifo_mem_d [rd_fifo_els_p];
  logic [ptr_w-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [occ_w-1:0]  occ_q, occ_d;

  logic                   fifo_full_c, fifo_empty_c;
  logic [id_w-1:0]        head_id_c;
  logic [num_cache_p-1:0] elig_c;
  logic                   any_elig_c;
  logic [id_w-1:0]        grant_arb_c, grant_c;
  logic                   pkt_v_c, pkt_xfer_c;
  logic [pkt_w-1:0]       gpkt_c;
  logic                   wdata_v_c, wxfer_c;
  logic                   rready_c, rxfer_c;
  logic [num_cache_p-1:0] pkt_yumi_c, wdata_yumi_c, rdata_v_c;

  assign fifo_full_c  = (occ_q == occ_w'(rd_fifo_els_p));
  assign fifo_empty_c = (occ_q == '0);
  assign head_id_c    = fifo_mem_q[rptr_q];

  // Reads are held back while the ID FIFO cannot take another entry.
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < num_cache_p; i++) begin
      elig_c[i] = bus.dma_pkt_v_i[i] & (bus.dma_pkt_i[i*pkt_w + addr_width_p] | ~fifo_full_c);
    end
  end

  // First eligible cache scanning upward from rr_q+1, wrapping.
  always_comb begin
    grant_arb_c = '0;
    any_elig_c  = 1'b0;
    for (int unsigned i = 0; i < num_cache_p; i++) begin
      if (!any_elig_c && elig_c[(32'(rr_q) + i + 32'd1) % num_cache_p]) begin
        any_elig_c  = 1'b1;
        grant_arb_c = id_w'((32'(rr_q) + i + 32'd1) % num_cache_p);
      end
    end
  end

  // Once a packet is offered the grant is frozen until memory takes it.
  assign grant_c    = offered_q ? grant_q : grant_arb_c;
  assign pkt_v_c    = reset_n_i & (state_q == ST_IDLE) & (offered_q | any_elig_c);
  assign pkt_xfer_c = pkt_v_c & bus.mem_pkt_yumi_i;
  assign gpkt_c     = bus.dma_pkt_i[32'(grant_c)*pkt_w +: pkt_w];

  assign wdata_v_c  = reset_n_i & (state_q == ST_WDATA) & bus.dma_wdata_v_i[owner_q];
  assign wxfer_c    = wdata_v_c & bus.mem_wdata_yumi_i;

  assign rready_c   = reset_n_i & ~fifo_empty_c & bus.dma_rdata_ready_i[head_id_c];
  assign rxfer_c    = rready_c & bus.mem_rdata_v_i;

  // One-hot steering of handshakes toward the granted/owning/head cache.
  always_comb begin
    pkt_yumi_c   = '0;
    wdata_yumi_c = '0;
    rdata_v_c    = '0;
    pkt_yumi_c[grant_c]     = pkt_xfer_c;
    wdata_yumi_c[owner_q]   = wxfer_c;
    rdata_v_c[head_id_c]    = reset_n_i & ~fifo_empty_c & bus.mem_rdata_v_i;
  end

  assign bus.dma_pkt_yumi_o    = pkt_yumi_c;
  assign bus.dma_wdata_yumi_o  = wdata_yumi_c;
  assign bus.dma_rdata_o       = bus.mem_rdata_i;
  assign bus.dma_rdata_v_o     = rdata_v_c;
  assign bus.mem_pkt_o         = gpkt_c;
  assign bus.mem_pkt_v_o       = pkt_v_c;
  assign bus.mem_wdata_o       = bus.dma_wdata_i[32'(owner_q)*data_width_p +: data_width_p];
  assign bus.mem_wdata_v_o     = wdata_v_c;
  assign bus.mem_rdata_ready_o = rready_c;

  // Next-state: packet/write FSM, fill counter and ID FIFO.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    grant_d    = grant_c;
    offered_d  = pkt_v_c & ~bus.mem_pkt_yumi_i;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    fifo_mem_d = fifo_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;

    if (pkt_xfer_c) begin
      rr_d = grant_c;
      if (gpkt_c[addr_width_p]) begin
        owner_d = grant_c;
        wcnt_d  = '0;
        state_d = ST_WDATA;
      end else begin
        fifo_mem_d[wptr_q] = grant_c;
        wptr_d = (wptr_q == ptr_w'(rd_fifo_els_p - 1)) ? '0 : wptr_q + ptr_w'(1);
      end
    end

    if (wxfer_c) begin
      if (wcnt_q == cnt_w'(block_size_in_words_p - 1)) begin
        wcnt_d  = '0;
        state_d = ST_IDLE;
      end else begin
        wcnt_d = wcnt_q + cnt_w'(1);
      end
    end

    if (rxfer_c) begin
      if (rcnt_q == cnt_w'(block_size_in_words_p - 1)) begin
        rcnt_d = '0;
        rptr_d = (rptr_q == ptr_w'(rd_fifo_els_p - 1)) ? '0 : rptr_q + ptr_w'(1);
      end else begin
        rcnt_d = rcnt_q + cnt_w'(1);
      end
    end

    // Push and pop together leave occupancy unchanged.
    case ({pkt_xfer_c & ~gpkt_c[addr_width_p], rxfer_c && (rcnt_q == cnt_w'(block_size_in_words_p - 1))})
      2'b10:   occ_d = occ_q + occ_w'(1);
      2'b01:   occ_d = occ_q - occ_w'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= id_w'(num_cache_p - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      offered_q <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      for (int unsigned i = 0; i < rd_fifo_els_p; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      offered_q  <= offered_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

`ifdef VCACHE_DMA_ARB_STATS_EN
  logic [31:0]               stat_grant_q [num_cache_p];
  logic [31:0]               stat_grant_d [num_cache_p];
  logic [31:0]               stat_wait_q  [num_cache_p];
  logic [31:0]               stat_wait_d  [num_cache_p];
  logic [num_cache_p*32-1:0] stat_grant_flat_c, stat_wait_flat_c;

  // Free-running per-cache grant and wait counters, wrapping at 2^32.
  always_comb begin
    stat_grant_flat_c = '0;
    stat_wait_flat_c  = '0;
    for (int unsigned i = 0; i < num_cache_p; i++) begin
      stat_grant_d[i] = stat_grant_q[i] + 32'(pkt_yumi_c[i]);
      stat_wait_d[i]  = stat_wait_q[i] + 32'(bus.dma_pkt_v_i[i] & ~pkt_yumi_c[i]);
      stat_grant_flat_c[i*32 +: 32] = stat_grant_q[i];
      stat_wait_flat_c[i*32 +: 32]  = stat_wait_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < num_cache_p; i++) begin
        stat_grant_q[i] <= '0;
        stat_wait_q[i]  <= '0;
      end
    end else begin
      stat_grant_q <= stat_grant_d;
      stat_wait_q  <= stat_wait_d;
    end
  end

  assign bus.stat_grant_o = stat_grant_flat_c;
  assign bus.stat_wait_o  = stat_wait_flat_c;
`else
  assign bus.stat_grant_o = '0;
  assign bus.stat_wait_o  = '0;
`endif

  // A fill beat arriving with no outstanding read ID is a protocol error.
  a_fill_has_id: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    bus.mem_rdata_v_i |-> !fifo_empty_c);

endmodule
